// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM crossbar write-port arbiter.
package cim_pkg;

  typedef enum logic [1:0] {
    s_arb_idle,
    s_arb_grant,
    s_arb_release
  } t_cim_arb_state;

  // Bit width needed to index n items; never narrower than one bit.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cim_xbar_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible index after last.
module rr_pick
  import cim_pkg::*;
#(
  parameter int unsigned num_req = 4,
  parameter int unsigned ow      = 2
) (
  input  logic [num_req-1:0] eligible,
  input  logic [ow-1:0]      last,
  output logic [ow-1:0]      winner,
  output logic               valid
);

  // Scan last+1, last+2, ... wrapping, and keep the first hit.
  always_comb begin
    int unsigned idx;
    logic [ow-1:0] sel;
    idx    = 0;
    sel    = '0;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned i = 1; i <= num_req; i++) begin
      idx = (32'(last) + i) % num_req;
      sel = idx[ow-1:0];
      if (!valid && eligible[sel]) begin
        valid  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/cim_xbar_arbiter.sv
// Round-robin arbiter sharing one CIM crossbar write port among num_req
// requesters. Non-owners see busy high and park in their idle state.
// Optional macro CIM_ARB_TIMEOUT_EN adds max_hold, o_timeout, a hold
// counter and a per-requester mask that forces release of long grants.
module cim_xbar_arbiter
  import cim_pkg::*;
#(
  parameter int unsigned num_req       = 4,
  parameter int unsigned xbar_size     = 256,
  parameter int unsigned datatype_size = 8,
`ifdef CIM_ARB_TIMEOUT_EN
  parameter int unsigned max_hold      = 1024,
`endif
  localparam int unsigned aw = clog2w(xbar_size),
  localparam int unsigned ow = clog2w(num_req),
  localparam int unsigned cw = clog2w(xbar_size * num_req + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [num_req-1:0]                   i_req,
  input  logic [num_req-1:0]                   i_we,
  input  logic [num_req-1:0][aw-1:0]           i_addr,
  input  logic [num_req-1:0][datatype_size-1:0] i_data,
  input  logic                                 i_cim_busy,
  output logic [num_req-1:0]                   o_grant,
  output logic [num_req-1:0]                   o_req_busy,
  output logic                                 o_cim_we,
  output logic [aw-1:0]                        o_cim_addr,
  output logic [datatype_size-1:0]             o_cim_data,
  output logic [ow-1:0]                        o_owner,
  output logic [cw-1:0]                        o_write_count
`ifdef CIM_ARB_TIMEOUT_EN
  ,
  output logic                                 o_timeout
`endif
);

  t_cim_arb_state state, state_next;

  logic [num_req-1:0] eligible;
  logic [num_req-1:0] owner_onehot;
  logic [ow-1:0]      pick_idx;
  logic               pick_valid;
  logic               take_grant;
  logic               owner_req;
  logic               hold_expired;

  assign owner_onehot = {{(num_req-1){1'b0}}, 1'b1} << o_owner;
  assign owner_req    = i_req[o_owner];
  assign take_grant   = (state == s_arb_idle) && pick_valid && !i_cim_busy;

`ifdef CIM_ARB_TIMEOUT_EN
  localparam int unsigned hw = clog2w(max_hold);
  localparam logic [hw-1:0] hold_last = hw'(max_hold - 1);

  logic [hw-1:0]      hold_cnt;
  logic [num_req-1:0] mask;

  assign hold_expired = (state == s_arb_grant) && owner_req && (hold_cnt == hold_last);
  assign eligible     = i_req & ~mask;
  assign o_timeout    = hold_expired;

  // Count cycles spent in the current grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_cnt <= '0;
    else if (state == s_arb_grant) hold_cnt <= hold_cnt + 1'b1;
    else hold_cnt <= '0;
  end

  // Mask a timed-out requester until it drops its request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mask <= '0;
    else mask <= (mask & i_req) | (hold_expired ? owner_onehot : '0);
  end
`else
  assign hold_expired = 1'b0;
  assign eligible     = i_req;
`endif

  rr_pick #(
    .num_req(num_req),
    .ow     (ow)
  ) u_pick (
    .eligible(eligible),
    .last    (o_owner),
    .winner  (pick_idx),
    .valid   (pick_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= s_arb_idle;
    else state <= state_next;
  end

  // Next-state decision.
  always_comb begin
    state_next = state;
    unique case (state)
      s_arb_idle:    if (take_grant) state_next = s_arb_grant;
      s_arb_grant:   if (!owner_req || hold_expired) state_next = s_arb_release;
      s_arb_release: state_next = s_arb_idle;
      default:       state_next = s_arb_idle;
    endcase
  end

  // Owner register; reset value makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_owner <= ow'(num_req - 1);
    else if (take_grant) o_owner <= pick_idx;
  end

  // Writes in the current grant, saturating, cleared on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_write_count <= '0;
    else if (state == s_arb_release) o_write_count <= '0;
    else if (o_cim_we && (o_write_count != '1)) o_write_count <= o_write_count + 1'b1;
  end

  // Grant, busy and crossbar port muxing from the current state.
  always_comb begin
    o_grant    = '0;
    o_req_busy = '1;
    o_cim_we   = 1'b0;
    o_cim_addr = '0;
    o_cim_data = '0;
    if (state == s_arb_grant) begin
      o_grant             = owner_onehot;
      o_req_busy[o_owner] = i_cim_busy;
      o_cim_we            = i_we[o_owner] & ~i_cim_busy;
      o_cim_addr          = i_addr[o_owner];
      o_cim_data          = i_data[o_owner];
    end
  end

endmodule

// File: tb/tb_cim_xbar_arbiter.sv
// Self-checking bench for cim_xbar_arbiter against a cycle reference model.
module tb_cim_xbar_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned XS = 256;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned OW = 2;
  localparam int unsigned CW = 11;
`ifdef CIM_ARB_TIMEOUT_EN
  localparam int unsigned MH = 8;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NR-1:0]          i_req;
  logic [NR-1:0]          i_we;
  logic [NR-1:0][AW-1:0]  i_addr;
  logic [NR-1:0][DW-1:0]  i_data;
  logic                   i_cim_busy;
  logic [NR-1:0]          o_grant;
  logic [NR-1:0]          o_req_busy;
  logic                   o_cim_we;
  logic [AW-1:0]          o_cim_addr;
  logic [DW-1:0]          o_cim_data;
  logic [OW-1:0]          o_owner;
  logic [CW-1:0]          o_write_count;
  logic                   o_timeout;

  cim_xbar_arbiter #(
    .num_req      (NR),
    .xbar_size    (XS),
    .datatype_size(DW)
`ifdef CIM_ARB_TIMEOUT_EN
    , .max_hold   (MH)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .i_cim_busy   (i_cim_busy),
    .o_grant      (o_grant),
    .o_req_busy   (o_req_busy),
    .o_cim_we     (o_cim_we),
    .o_cim_addr   (o_cim_addr),
    .o_cim_data   (o_cim_data),
    .o_owner      (o_owner),
    .o_write_count(o_write_count)
`ifdef CIM_ARB_TIMEOUT_EN
    , .o_timeout  (o_timeout)
`endif
  );

`ifndef CIM_ARB_TIMEOUT_EN
  assign o_timeout = 1'b0;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the port (-1 = nobody), whether a release
  // cycle is pending, last winner, writes so far, grant age, masked units.
  int           m_gnt;
  bit           m_cool;
  int           m_last;
  int           m_cnt;
  int           m_hold;
  bit [NR-1:0]  m_mask;
  int           last_we_unit;

  // Observations of the DUT used for order / timing checks.
  int           dut_order[$];
  logic [NR-1:0] prev_grant;
  int           gcyc;
  int           to_at;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt        = -1;
    m_cool       = 1'b0;
    m_last       = NR - 1;
    m_cnt        = 0;
    m_hold       = 0;
    m_mask       = '0;
    last_we_unit = -1;
    prev_grant   = '0;
    gcyc         = 0;
  endtask

  task automatic idle_inputs();
    i_req      = '0;
    i_we       = '0;
    i_addr     = '0;
    i_data     = '0;
    i_cim_busy = 1'b0;
  endtask

  // Called at a falling edge; asynchronously resets mid-cycle.
  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    check_eq("rst_grant", o_grant, '0);
    check_eq("rst_busy", o_req_busy, 4'hF);
    check_eq("rst_we", o_cim_we, 1'b0);
    check_eq("rst_addr", o_cim_addr, '0);
    check_eq("rst_data", o_cim_data, '0);
    check_eq("rst_owner", o_owner, NR - 1);
    check_eq("rst_wcount", o_write_count, 0);
`ifdef CIM_ARB_TIMEOUT_EN
    check_eq("rst_timeout", o_timeout, 1'b0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic step();
    logic [NR-1:0] e_grant, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_we, e_to;
    bit            found;
    int            idx;
    #1;
    e_grant = '0;
    e_busy  = '1;
    e_we    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    e_to    = 1'b0;
    if (m_gnt >= 0) begin
      e_grant[m_gnt] = 1'b1;
      e_busy[m_gnt]  = i_cim_busy;
      e_we           = i_we[m_gnt] & ~i_cim_busy;
      e_addr         = i_addr[m_gnt];
      e_data         = i_data[m_gnt];
`ifdef CIM_ARB_TIMEOUT_EN
      e_to = i_req[m_gnt] && (m_hold == MH - 1);
`endif
    end
    check_eq("grant", o_grant, e_grant);
    check_eq("busy", o_req_busy, e_busy);
    check_eq("we", o_cim_we, e_we);
    check_eq("addr", o_cim_addr, e_addr);
    check_eq("data", o_cim_data, e_data);
    check_eq("owner", o_owner, m_last);
    check_eq("wcount", o_write_count, m_cnt);
`ifdef CIM_ARB_TIMEOUT_EN
    check_eq("timeout", o_timeout, e_to);
`endif
    if (o_grant != '0 && prev_grant == '0) begin
      dut_order.push_back(int'(o_owner));
      gcyc = 0;
    end
    if (o_grant != '0) gcyc++;
    if (o_timeout) to_at = gcyc;
    prev_grant   = o_grant;
    last_we_unit = e_we ? m_gnt : -1;

    @(posedge clk);
    if (m_gnt >= 0) begin
      if (e_we && m_cnt < (1 << CW) - 1) m_cnt++;
      if (!i_req[m_gnt] || e_to) begin
        if (e_to) m_mask[m_gnt] = 1'b1;
        m_gnt  = -1;
        m_cool = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
      m_cnt  = 0;
    end else if (!i_cim_busy) begin
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (!found && i_req[idx] && !m_mask[idx]) begin
          found  = 1'b1;
          m_gnt  = idx;
          m_last = idx;
          m_hold = 0;
        end
      end
    end
    for (int i = 0; i < NR; i++) if (!i_req[i]) m_mask[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int rem[NR];
    idle_inputs();
    model_reset();
    to_at = 0;
    @(negedge clk);

    // Single requester writes 256 rows, then drops.
    do_reset();
    i_req = 4'b0001;
    i_we  = 4'b0001;
    for (int c = 0; c < 257; c++) begin
      i_addr[0] = AW'(c - 1);
      i_data[0] = DW'($urandom);
      step();
    end
`ifndef CIM_ARB_TIMEOUT_EN
    check_eq("wcount256", o_write_count, 256);
`endif
    i_req = '0;
    i_we  = '0;
    for (int c = 0; c < 3; c++) step();

    // All four request; each writes 4 rows then drops.
    idle_inputs();
    do_reset();
    dut_order.delete();
    for (int i = 0; i < NR; i++) rem[i] = 4;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NR; i++) begin
        i_req[i]  = rem[i] > 0;
        i_we[i]   = rem[i] > 0;
        i_addr[i] = AW'($urandom);
        i_data[i] = DW'($urandom);
      end
      step();
      if (last_we_unit >= 0) rem[last_we_unit]--;
    end
    check_eq("rr_count", dut_order.size(), 4);
    for (int k = 0; k < dut_order.size(); k++) check_eq("rr_order", dut_order[k], k);

    // Crossbar busy for 5 cycles in the middle of a grant.
    idle_inputs();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      i_cim_busy = (c >= 2) && (c <= 6);
      i_req[1]   = c < 8;
      i_we[1]    = c < 8;
      i_addr[1]  = AW'($urandom);
      i_data[1]  = DW'($urandom);
      if (c == 6) begin
        #1;
        check_eq("busy_hold_grant", o_grant, 4'b0010);
        check_eq("busy_hold_wcount", o_write_count, 1);
        check_eq("busy_hold_owner_busy", o_req_busy, 4'hF);
      end
      step();
    end

    // Reset while unit 2 owns the port; then 2 and 0 request together.
    idle_inputs();
    do_reset();
    i_req = 4'b0100;
    i_we  = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      i_addr[2] = AW'($urandom);
      step();
    end
    do_reset();
    i_req = 4'b0101;
    i_we  = 4'b0000;
    step();
    step();
    #1;
    check_eq("rst_regrant", o_grant, 4'b0001);
    i_req = '0;
    for (int c = 0; c < 3; c++) step();

`ifdef CIM_ARB_TIMEOUT_EN
    // Unit 1 holds its request past max_hold; unit 3 also waiting.
    idle_inputs();
    do_reset();
    dut_order.delete();
    to_at = 0;
    i_req = 4'b1010;
    i_we  = 4'b1010;
    for (int c = 0; c < 24; c++) step();
    check_eq("to_cycle", to_at, MH);
    i_req = 4'b1000;
    step();
    i_req = 4'b1010;
    for (int c = 0; c < 4; c++) step();
    i_req = '0;
    i_we  = '0;
    for (int c = 0; c < 3; c++) step();
    check_eq("to_order_n", dut_order.size(), 3);
    if (dut_order.size() == 3) begin
      check_eq("to_order0", dut_order[0], 1);
      check_eq("to_order1", dut_order[1], 3);
      check_eq("to_order2", dut_order[2], 1);
    end
`endif

    // Request held for the decision cycle only.
    idle_inputs();
    do_reset();
    i_req = 4'b0001;
    i_we  = 4'b0001;
    step();
    i_req = '0;
    i_we  = '0;
    step();
    #1;
    check_eq("drop_wcount", o_write_count, 0);
    check_eq("drop_release_grant", o_grant, '0);
    step();
    step();

    // Randomized traffic.
    idle_inputs();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 7) == 0) i_req[i] = ~i_req[i];
        i_we[i]   = 1'($urandom_range(0, 1));
        i_addr[i] = AW'($urandom);
        i_data[i] = DW'($urandom);
      end
      i_cim_busy = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
